// File: rtl/dram_pack_pkg.sv
// Shared types and helpers for the DRAM frame packer sequencer.
package dram_pack_pkg;

    localparam int FRAME_WORDS = 17;
    localparam int CHUNK_WORDS = 4;
    localparam int WORD_W      = 16;
    localparam int DATA_W      = CHUNK_WORDS * WORD_W;
    localparam int FILL_W      = 5;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        REM  = 2'd2,
        PAD  = 2'd3
    } state_t;

    // Packer len code: the packer shifts in (5 - len) words.
    function automatic logic [3:0] words2len(input logic [2:0] n);
        logic [3:0] len;
        case (n)
            3'd1:    len = 4'd4;
            3'd2:    len = 4'd3;
            3'd3:    len = 4'd2;
            3'd4:    len = 4'd1;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic len_legal(input logic [2:0] n);
        return (n >= 3'd1) && (n <= 3'(CHUNK_WORDS));
    endfunction

endpackage

// File: rtl/dram_pack_split.sv
// Splits an incoming chunk at the frame boundary: words that still fit,
// words left over, and the leftover data realigned to word 0.
module dram_pack_split
    import dram_pack_pkg::*;
(
    input  logic [FILL_W-1:0] fill,
    input  logic [2:0]        n,
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        pack_n,
    output logic [2:0]        rem_n,
    output logic [DATA_W-1:0] rem_data,
    output logic              crosses
);

    logic [FILL_W-1:0] room_s;

    // Room left in the frame and the resulting split of the chunk.
    always_comb begin
        room_s   = 5'(FRAME_WORDS) - fill;
        crosses  = ({2'b00, n} > room_s);
        pack_n   = n;
        rem_n    = 3'd0;
        rem_data = '0;
        if (crosses) begin
            pack_n   = room_s[2:0];
            rem_n    = n - room_s[2:0];
            rem_data = data >> {pack_n, 4'b0000};
        end else begin
            pack_n   = n;
            rem_n    = 3'd0;
            rem_data = '0;
        end
    end

endmodule

// File: rtl/dram_pack_ctrl.sv
// Sequencer feeding the 272-bit DRAM frame packer from valid/ready chunks.
// Optional zero-padding flush is compiled in with DRAM_PACK_FLUSH_EN.
module dram_pack_ctrl
    import dram_pack_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_words,
    input  logic              flush,
    output logic [DATA_W-1:0] pk_din,
    output logic [3:0]        pk_len,
    output logic              pk_ce,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              bad_len
);

    state_t              state_r;
    state_t              state_nx_s;
    logic [FILL_W-1:0]   fill_r;
    logic [DATA_W-1:0]   hold_r;
    logic [2:0]          hold_n_r;
    logic [CNT_W-1:0]    frame_cnt_r;
    logic                bad_len_r;

    logic                legal_s;
    logic                accept_s;
    logic                handoff_s;
    logic                completes_s;
    logic                pad_go_s;
    logic [FILL_W-1:0]   room_s;
    logic [2:0]          pack_n_s;
    logic [2:0]          rem_n_s;
    logic [DATA_W-1:0]   rem_data_s;
    logic                crosses_s;

    dram_pack_split u_split (
        .fill     (fill_r),
        .n        (in_words),
        .data     (in_data),
        .pack_n   (pack_n_s),
        .rem_n    (rem_n_s),
        .rem_data (rem_data_s),
        .crosses  (crosses_s)
    );

`ifdef DRAM_PACK_FLUSH_EN
    logic                flush_pend_r;
    logic [2:0]          pad_n_s;

    // A pending flush (or an idle-cycle flush) starts padding only if the frame is non-empty.
    assign pad_go_s = (state_r == FILL) && (fill_r != 5'd0) &&
                      (flush_pend_r || (flush && !in_valid));
    assign pad_n_s  = (room_s > 5'd4) ? 3'd4 : room_s[2:0];
`else
    logic                flush_unused_s;

    assign flush_unused_s = flush;
    assign pad_go_s       = 1'b0;
`endif

    assign room_s      = 5'(FRAME_WORDS) - fill_r;
    assign legal_s     = len_legal(in_words);
    assign in_ready    = !rst && (state_r == FILL) && !pad_go_s;
    assign accept_s    = in_valid && in_ready;
    assign handoff_s   = (state_r == FULL) && frame_ready;
    assign completes_s = accept_s && legal_s && ({2'b00, in_words} >= room_s);

    assign frame_valid = (state_r == FULL);
    assign frame_cnt   = frame_cnt_r;
    assign bad_len     = bad_len_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            FILL: begin
                if (pad_go_s) begin
                    state_nx_s = PAD;
                end else if (completes_s) begin
                    state_nx_s = FULL;
                end else begin
                    state_nx_s = FILL;
                end
            end
            FULL: begin
                if (handoff_s) begin
                    state_nx_s = (hold_n_r != 3'd0) ? REM : FILL;
                end else begin
                    state_nx_s = FULL;
                end
            end
            REM: state_nx_s = FILL;
`ifdef DRAM_PACK_FLUSH_EN
            PAD: begin
                if ({2'b00, pad_n_s} == room_s) begin
                    state_nx_s = FULL;
                end else begin
                    state_nx_s = PAD;
                end
            end
`endif
            default: state_nx_s = FILL;
        endcase
    end

    // Packer drive: combinational so the packer's own register lands data one cycle later.
    always_comb begin
        pk_ce  = 1'b0;
        pk_din = '0;
        pk_len = 4'd0;
        case (state_r)
            FILL: begin
                if (accept_s && legal_s) begin
                    pk_ce  = 1'b1;
                    pk_din = in_data;
                    pk_len = words2len(pack_n_s);
                end else begin
                    pk_ce  = 1'b0;
                    pk_din = '0;
                    pk_len = 4'd0;
                end
            end
            REM: begin
                pk_ce  = 1'b1;
                pk_din = hold_r;
                pk_len = words2len(hold_n_r);
            end
`ifdef DRAM_PACK_FLUSH_EN
            PAD: begin
                pk_ce  = 1'b1;
                pk_din = '0;
                pk_len = words2len(pad_n_s);
            end
`endif
            default: begin
                pk_ce  = 1'b0;
                pk_din = '0;
                pk_len = 4'd0;
            end
        endcase
    end

    // Fill level, split remainder, frame counter and sticky length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_r      <= 5'd0;
            hold_r      <= '0;
            hold_n_r    <= 3'd0;
            frame_cnt_r <= '0;
            bad_len_r   <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s && legal_s && crosses_s) begin
                        fill_r   <= 5'(FRAME_WORDS);
                        hold_r   <= rem_data_s;
                        hold_n_r <= rem_n_s;
                    end else if (accept_s && legal_s) begin
                        fill_r   <= fill_r + {2'b00, in_words};
                    end else if (accept_s) begin
                        bad_len_r <= 1'b1;
                    end
                end
                FULL: begin
                    if (handoff_s) begin
                        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                        fill_r      <= 5'd0;
                    end
                end
                REM: begin
                    fill_r   <= {2'b00, hold_n_r};
                    hold_n_r <= 3'd0;
                    hold_r   <= '0;
                end
`ifdef DRAM_PACK_FLUSH_EN
                PAD: fill_r <= fill_r + {2'b00, pad_n_s};
`endif
                default: fill_r <= fill_r;
            endcase
        end
    end

`ifdef DRAM_PACK_FLUSH_EN
    // A flush arriving with a chunk waits for the next FILL cycle; any other FILL cycle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend_r <= 1'b0;
        end else if (state_r == FILL) begin
            flush_pend_r <= accept_s && flush;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end
`endif

endmodule
